// File: rtl/freq_div_pkg.sv
// Shared types and wait arithmetic for the divider ratio-change sequencer.
// Handover wait is 4*r + settle, with r<=1 treated as 1.
package freq_div_pkg;

  typedef enum logic [2:0] {IDLE, TO_BYP, LOAD, WARM, TO_DIV, DONE} state_t;

  localparam int unsigned WAIT_EXTRA_W = 3;

  function automatic int unsigned wait_cnt_w(input int unsigned div_w);
    return div_w + WAIT_EXTRA_W;
  endfunction

  function automatic int unsigned handover_wait(input int unsigned r, input int unsigned settle);
    return 4 * ((r <= 1) ? 1 : r) + settle;
  endfunction

endpackage

// File: rtl/freq_switch_ctrl_wait_timer.sv
// Loadable down-counter; expire pulses for one cycle on the last cycle of a load_val-long wait.
// The count saturates at zero, so it never wraps.
module wait_timer #(
  parameter int unsigned CNT_W = 11
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (load)           cnt <= load_val;
    else if (cnt != '0)      cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/freq_switch_ctrl.sv
// Glitch-free divider ratio-change sequencer: park mux on clkin, reload divider, warm up, hand back.
// Optional FREQ_SWITCH_CTRL_ERR_EN: out-of-range ratios are rejected with err instead of clamped.
module freq_switch_ctrl
  import freq_div_pkg::*;
#(
  parameter int unsigned DIV_W         = 8,
  parameter int unsigned MAX_RATIO     = 255,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned LOCK_MULT     = 2
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [DIV_W-1:0] req_ratio,
  output logic             req_ready,
  output logic [DIV_W-1:0] div_ratio,
  output logic             div_load,
  output logic             div_rst,
  output logic             bypass,
  output logic             busy,
  output logic             done
`ifdef FREQ_SWITCH_CTRL_ERR_EN
  ,
  output logic             err
`endif
);

  localparam int unsigned      CNT_W = wait_cnt_w(DIV_W);
  localparam logic [DIV_W-1:0] MAX_R = DIV_W'(MAX_RATIO);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cur_ratio, cur_nxt, new_ratio, new_nxt;
  logic [DIV_W-1:0] req_new, div_ratio_nxt;
  logic             req_oor, req_err;
  logic             tmr_load, tmr_exp;
  logic [CNT_W-1:0] tmr_val;
  logic             bypass_nxt, div_rst_nxt;

  assign req_oor = (req_ratio > MAX_R);
`ifdef FREQ_SWITCH_CTRL_ERR_EN
  assign req_new = req_ratio;
  assign req_err = req_oor;
`else
  assign req_new = req_oor ? MAX_R : req_ratio;
  assign req_err = 1'b0;
`endif

  wait_timer #(.CNT_W(CNT_W)) u_timer (
    .clkin    (clkin),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_exp)
  );

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_ratio;
    new_nxt   = new_ratio;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      IDLE: if (req_valid) begin
        new_nxt = req_new;
        if (req_err || req_new == cur_ratio || (req_new <= ONE && cur_ratio <= ONE)) begin
          state_nxt = DONE;
        end else if (cur_ratio <= ONE) begin
          state_nxt = LOAD;
        end else begin
          // Extra cycle lets the mux switch before the old-clock handover window starts.
          state_nxt = TO_BYP;
          tmr_load  = 1'b1;
          tmr_val   = CNT_W'(handover_wait(32'(cur_ratio), SETTLE_CYCLES) + 32'd1);
        end
      end
      TO_BYP: if (tmr_exp) state_nxt = LOAD;
      LOAD: begin
        cur_nxt = new_ratio;
        if (new_ratio <= ONE) begin
          state_nxt = DONE;
        end else begin
          state_nxt = WARM;
          tmr_load  = 1'b1;
          tmr_val   = CNT_W'(LOCK_MULT * 32'(new_ratio));
        end
      end
      WARM: if (tmr_exp) begin
        state_nxt = TO_DIV;
        tmr_load  = 1'b1;
        tmr_val   = CNT_W'(handover_wait(32'(new_ratio), SETTLE_CYCLES));
      end
      TO_DIV: if (tmr_exp) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave flops in step with the state register.
  always_comb begin
    bypass_nxt    = bypass;
    div_rst_nxt   = div_rst;
    div_ratio_nxt = div_ratio;
    if (state_nxt == TO_BYP) bypass_nxt = 1'b1;
    if (state_nxt == TO_DIV) bypass_nxt = 1'b0;
    if (state_nxt == LOAD) begin
      div_rst_nxt   = 1'b1;
      div_ratio_nxt = new_nxt;
    end
    if (state_nxt == WARM) div_rst_nxt = 1'b0;
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_ratio <= ONE;
      new_ratio <= '0;
      div_ratio <= '0;
      div_load  <= 1'b0;
      div_rst   <= 1'b1;
      bypass    <= 1'b1;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_ratio <= cur_nxt;
      new_ratio <= new_nxt;
      div_ratio <= div_ratio_nxt;
      div_load  <= (state_nxt == LOAD);
      div_rst   <= div_rst_nxt;
      bypass    <= bypass_nxt;
      req_ready <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
    end
  end

`ifdef FREQ_SWITCH_CTRL_ERR_EN
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= (state == IDLE) && req_valid && req_err;
  end
`endif

endmodule

// File: tb/tb_freq_switch_ctrl.sv
// Bench for freq_switch_ctrl: directed and random ratio changes checked against a timing model.
module tb_freq_switch_ctrl;

  localparam int DW   = 9;
  localparam int MAXR = 255;
  localparam int SET  = 4;
  localparam int LM   = 2;
  localparam int TMO  = 4000;

  logic          clkin, rst, req_valid, req_ready, div_load, div_rst, bypass, busy, done;
  logic [DW-1:0] req_ratio, div_ratio;
`ifdef FREQ_SWITCH_CTRL_ERR_EN
  logic          err;
`endif

  int n_tests, n_fail;
  int m_cur, m_ratio;
  bit m_byp, m_rst;

  freq_switch_ctrl #(.DIV_W(DW), .MAX_RATIO(MAXR), .SETTLE_CYCLES(SET), .LOCK_MULT(LM)) dut (
    .clkin     (clkin),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ratio (req_ratio),
    .req_ready (req_ready),
    .div_ratio (div_ratio),
    .div_load  (div_load),
    .div_rst   (div_rst),
    .bypass    (bypass),
    .busy      (busy),
    .done      (done)
`ifdef FREQ_SWITCH_CTRL_ERR_EN
    ,
    .err       (err)
`endif
  );

  always #5 clkin = ~clkin;

  function automatic int wt(input int r);
    return 4 * ((r <= 1) ? 1 : r) + SET;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = 1; m_ratio = 0; m_byp = 1; m_rst = 1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " div_ratio"}, int'(div_ratio), 0);
    chk({tag, " div_load"},  int'(div_load), 0);
    chk({tag, " div_rst"},   int'(div_rst), 1);
    chk({tag, " bypass"},    int'(bypass), 1);
    chk({tag, " req_ready"}, int'(req_ready), 1);
    chk({tag, " busy"},      int'(busy), 0);
    chk({tag, " done"},      int'(done), 0);
  endtask

  task automatic do_req(input int r);
    int nw, e_done, e_load, e_rise, e_fall, e_ratio;
    int done_k, load_k, n_load, rise_k, fall_k, n_edge, n_busy, ratio_ld, n_err, k;
    bit is_err;
    logic prev_byp;
    string t;
    t = $sformatf("req%0d(cur%0d)", r, m_cur);
    is_err = 0;
`ifdef FREQ_SWITCH_CTRL_ERR_EN
    is_err = (r > MAXR);
    nw = r;
`else
    nw = (r > MAXR) ? MAXR : r;
`endif
    e_load = 0; e_rise = 0; e_fall = 0;
    if (is_err || nw == m_cur || (nw <= 1 && m_cur <= 1)) begin
      e_done = 1;
    end else if (m_cur <= 1) begin
      e_load = 1;
      e_fall = 2 + LM * nw;
      e_done = e_fall + wt(nw);
    end else begin
      e_rise = 1;
      e_load = 2 + wt(m_cur);
      if (nw <= 1) begin
        e_done = e_load + 1;
      end else begin
        e_fall = e_load + 1 + LM * nw;
        e_done = e_fall + wt(nw);
      end
    end
    e_ratio = (e_load != 0) ? nw : -1;
    if (e_load != 0) begin
      m_cur = nw; m_ratio = nw; m_rst = (nw <= 1); m_byp = (nw <= 1);
    end

    @(negedge clkin);
    prev_byp = bypass;
    req_ratio = DW'(r);
    req_valid = 1'b1;
    done_k = 0; load_k = 0; n_load = 0; rise_k = 0; fall_k = 0;
    n_edge = 0; n_busy = 0; ratio_ld = -1; n_err = 0; k = 0;
    while (done_k == 0 && k < TMO) begin
      @(negedge clkin);
      k++;
      if (div_load) begin
        n_load++;
        if (load_k == 0) load_k = k;
        ratio_ld = int'(div_ratio);
      end
      if (bypass !== prev_byp) begin
        n_edge++;
        if (bypass && rise_k == 0) rise_k = k;
        if (!bypass && fall_k == 0) fall_k = k;
      end
      prev_byp = bypass;
      if (busy) n_busy++;
`ifdef FREQ_SWITCH_CTRL_ERR_EN
      if (err) n_err++;
`endif
      if (done) begin
        done_k = k;
        req_valid = 1'b0;
      end else begin
        // Held request during busy must be ignored, not queued.
        req_ratio = DW'($urandom_range(0, 511));
      end
    end
    req_valid = 1'b0;
    chk({t, " done_at"},   done_k, e_done);
    chk({t, " load_at"},   load_k, e_load);
    chk({t, " n_load"},    n_load, (e_load != 0) ? 1 : 0);
    chk({t, " ratio_ld"},  ratio_ld, e_ratio);
    chk({t, " byp_rise"},  rise_k, e_rise);
    chk({t, " byp_fall"},  fall_k, e_fall);
    chk({t, " byp_edges"}, n_edge, ((e_rise != 0) ? 1 : 0) + ((e_fall != 0) ? 1 : 0));
    chk({t, " busy_cyc"},  n_busy, e_done);
`ifdef FREQ_SWITCH_CTRL_ERR_EN
    chk({t, " err"},       n_err, is_err ? 1 : 0);
`endif
    @(negedge clkin);
    chk({t, " ready_after"}, int'(req_ready), 1);
    chk({t, " busy_after"},  int'(busy), 0);
    chk({t, " bypass_end"},  int'(bypass), int'(m_byp));
    chk({t, " div_rst_end"}, int'(div_rst), int'(m_rst));
    chk({t, " div_ratio"},   int'(div_ratio), m_ratio);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    clkin = 1'b0; rst = 1'b1; req_valid = 1'b0; req_ratio = '0;
    model_reset();
    #1;
    chk_reset_outputs("reset");
    repeat (3) @(negedge clkin);
    rst = 1'b0;

    do_req(4);
    do_req(8);
    do_req(1);
    do_req(1);
    do_req(0);
    do_req(5);
    do_req(5);
    do_req(300);
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 4) == 0) do_req(m_cur);
      else do_req(int'($urandom_range(0, 40)));
    end
    do_req(1);

    // Reset while the divider is warming up.
    @(negedge clkin);
    req_ratio = DW'(6);
    req_valid = 1'b1;
    @(negedge clkin);
    req_valid = 1'b0;
    repeat (2) @(negedge clkin);
    chk("warm busy", int'(busy), 1);
    chk("warm div_rst", int'(div_rst), 0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    model_reset();
    @(negedge clkin);
    rst = 1'b0;
    do_req(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
